alu_pipe: RTL and testbench

- Parametrised, pipelined successor of the team's 6-bit four-mode signed ALU.
- Keeps the same four operations (shift-add, add-multiply, negate, absolute) at generic WIDTH.
- Adds valid/ready handshaking, a 2-stage pipeline with backpressure, overflow detection, optional saturation and a sticky overflow counter.
- Sits between an operand source and a result sink on the datapath.

---
 rtl/alu_pipe_pkg.sv | 15 +
 rtl/alu_pipe_core.sv | 62 ++++++
 rtl/alu_pipe.sv | 116 +++++++++++
 tb/tb_alu_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined signed ALU.
//   mode_e : operation select encoding carried through the pipeline
//   IW_EXT : guard bits added to WIDTH so every operation is exact internally
package alu_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT_ADD = 2'b00,
    MODE_ADD_MUL   = 2'b01,
    MODE_NEG       = 2'b10,
    MODE_ABS       = 2'b11
  } mode_e;

  localparam int IW_EXT = 3;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU core: computes one of four signed operations exactly at
// WIDTH+IW_EXT bits, flags results outside the WIDTH signed range and formats
// them by clamping (SATURATE=1) or truncating (SATURATE=0).
// Ports:
//   a_i, b_i  : signed WIDTH-bit operands
//   mode_i    : operation select
//   result_o  : formatted signed WIDTH-bit result
//   ovf_o     : exact result did not fit in WIDTH signed bits
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int SATURATE = 1
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  mode_e                   mode_i,
  output logic signed [WIDTH-1:0] result_o,
  output logic                    ovf_o
);

  localparam int IW = WIDTH + IW_EXT;

  // Range limits of a WIDTH-bit signed value, expressed at IW bits.
  localparam logic signed [IW-1:0] MAXV = {{(IW_EXT+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(IW_EXT+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [IW-1:0] a_x;
  logic signed [IW-1:0] b_x;
  logic signed [IW-1:0] diff;
  logic signed [IW-1:0] raw;

  function automatic logic signed [WIDTH-1:0] fmt_result(
    input logic signed [IW-1:0] v,
    input logic                 ovf
  );
    if ((SATURATE != 0) && ovf) begin
      fmt_result = v[IW-1] ? MINV[WIDTH-1:0] : MAXV[WIDTH-1:0];
    end else begin
      fmt_result = v[WIDTH-1:0];
    end
  endfunction

  assign a_x = signed'({{IW_EXT{a_i[WIDTH-1]}}, a_i});
  assign b_x = signed'({{IW_EXT{b_i[WIDTH-1]}}, b_i});

  always_comb begin
    raw  = '0;
    diff = (a_x <<< 1) - b_x;
    case (mode_i)
      MODE_SHIFT_ADD: raw = (a_x <<< 2) + (b_x >>> 1);
      MODE_ADD_MUL:   raw = a_x + (b_x <<< 1) + b_x;
      MODE_NEG:       raw = -b_x;
      MODE_ABS:       raw = diff[IW-1] ? -diff : diff;
      default:        raw = '0;
    endcase
  end

  assign ovf_o    = (raw > MAXV) || (raw < MINV);
  assign result_o = fmt_result(raw, ovf_o);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined signed ALU with overflow reporting and a
// saturating overflow event counter.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_a, in_b, in_mode operand beat
//   out_valid/out_ready : result handshake; out_result, out_ovf result beat
//   ovf_count           : overflowed results delivered, saturating at all-ones
//   ovf_clear           : synchronous clear of ovf_count (wins over increment)
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_result,
  output logic                    out_ovf,
  output logic [CNT_W-1:0]        ovf_count,
  input  logic                    ovf_clear
);

  logic                    en1, en2;
  logic                    s1_vld_q, s1_vld_d;
  logic signed [WIDTH-1:0] s1_a_q, s1_a_d;
  logic signed [WIDTH-1:0] s1_b_q, s1_b_d;
  mode_e                   s1_mode_q, s1_mode_d;
  logic                    s2_vld_q, s2_vld_d;
  logic signed [WIDTH-1:0] s2_res_q, s2_res_d;
  logic                    s2_ovf_q, s2_ovf_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] core_res;
  logic                    core_ovf;

  // A stage may load when it is empty or when the stage after it moves on.
  assign en2      = !s2_vld_q || out_ready;
  assign en1      = !s1_vld_q || en2;
  assign in_ready = en1;

  // ---- stage 1 -> core -> stage 2 boundary ----
  alu_pipe_core #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_core (
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .mode_i  (s1_mode_q),
    .result_o(core_res),
    .ovf_o   (core_ovf)
  );

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_mode_d = s1_mode_q;
    s2_vld_d  = s2_vld_q;
    s2_res_d  = s2_res_q;
    s2_ovf_d  = s2_ovf_q;
    cnt_d     = cnt_q;
    if (en1) begin
      s1_vld_d  = in_valid && en1;
      s1_a_d    = in_a;
      s1_b_d    = in_b;
      s1_mode_d = mode_e'(in_mode);
    end
    // An empty s1 propagates as a bubble into s2.
    if (en2) begin
      s2_vld_d = s1_vld_q;
      s2_res_d = core_res;
      s2_ovf_d = core_ovf;
    end
    if (ovf_clear) begin
      cnt_d = '0;
    end else if (s2_vld_q && out_ready && s2_ovf_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---- pipeline registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_mode_q <= MODE_SHIFT_ADD;
      s2_vld_q  <= 1'b0;
      s2_res_q  <= '0;
      s2_ovf_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_mode_q <= s1_mode_d;
      s2_vld_q  <= s2_vld_d;
      s2_res_q  <= s2_res_d;
      s2_ovf_q  <= s2_ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid  = s2_vld_q;
  assign out_result = s2_res_q;
  assign out_ovf    = s2_ovf_q;
  assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=6: a saturating and a wrapping
// instance share all inputs; a negedge monitor checks every delivered result
// and the overflow counter against an arithmetic reference model.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic ovf_clear = 1'b0;
  logic signed [5:0] in_a = '0;
  logic signed [5:0] in_b = '0;
  logic [1:0] in_mode = '0;

  logic rdy_s, rdy_w, ov_s, ov_w, of_s, of_w;
  logic signed [5:0] res_s, res_w;
  logic [7:0] cnt_s, cnt_w;

  alu_pipe #(.WIDTH(6), .SATURATE(1), .CNT_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(ov_s),
    .out_ready(out_ready), .out_result(res_s), .out_ovf(of_s),
    .ovf_count(cnt_s), .ovf_clear(ovf_clear));

  alu_pipe #(.WIDTH(6), .SATURATE(0), .CNT_W(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(ov_w),
    .out_ready(out_ready), .out_result(res_w), .out_ovf(of_w),
    .ovf_count(cnt_w), .ovf_clear(ovf_clear));

  always #5 clk = ~clk;

  typedef struct {int a; int b; int m;} beat_t;
  beat_t q[$];
  int total = 0;
  int bad = 0;
  int model_cnt = 0;
  logic stall_prev = 1'b0;
  logic signed [5:0] prev_res = '0;
  logic prev_ovf = 1'b0;
  logic done = 1'b0;

  // ---------------- reference model ----------------
  function automatic int fdiv2(int b);
    return (b < 0 && (b % 2) != 0) ? (b - 1) / 2 : b / 2;
  endfunction

  function automatic int true_val(int a, int b, int m);
    int d;
    case (m)
      0: return a * 4 + fdiv2(b);
      1: return a + 3 * b;
      2: return -b;
      default: begin
        d = 2 * a - b;
        return (d < 0) ? -d : d;
      end
    endcase
  endfunction

  function automatic int is_ovf(int v);
    return (v > 31 || v < -32) ? 1 : 0;
  endfunction

  function automatic int sat_of(int v);
    return (v > 31) ? 31 : ((v < -32) ? -32 : v);
  endfunction

  function automatic int wrap_of(int v);
    int r;
    r = ((v % 64) + 64) % 64;
    return (r >= 32) ? r - 64 : r;
  endfunction

  function automatic int s6(int u);
    return (u >= 32) ? u - 64 : u;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    beat_t bt;
    int tv;
    int xo;
    if (!rst_n) begin
      q.delete();
      model_cnt = 0;
      stall_prev = 1'b0;
    end else begin
      chk("ovf_count_sat", cnt_s, model_cnt);
      chk("ovf_count_wrap", cnt_w, model_cnt);
      if (stall_prev) begin
        chk("hold_valid", ov_s, 1);
        chk("hold_result", res_s, prev_res);
        chk("hold_ovf", of_s, prev_ovf);
      end
      xo = 0;
      if (ov_s && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_output", q.size(), 1);
        end else begin
          bt = q.pop_front();
          tv = true_val(bt.a, bt.b, bt.m);
          chk("result_sat", res_s, sat_of(tv));
          chk("result_wrap", res_w, wrap_of(tv));
          chk("ovf_sat", of_s, is_ovf(tv));
          chk("ovf_wrap", of_w, is_ovf(tv));
          xo = is_ovf(tv);
        end
      end
      if (ovf_clear) model_cnt = 0;
      else if (xo != 0 && model_cnt < 255) model_cnt++;
      if (in_valid && rdy_s) begin
        bt.a = int'(in_a);
        bt.b = int'(in_b);
        bt.m = int'(in_mode);
        q.push_back(bt);
      end
      stall_prev = ov_s && !out_ready;
      prev_res = res_s;
      prev_ovf = of_s;
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send(input int a, input int b, input int m);
    logic r;
    logic acc;
    in_a = a[5:0];
    in_b = b[5:0];
    in_mode = m[1:0];
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      r = rdy_s;
      @(posedge clk);
      acc = r;
    end
    if (!acc) chk("send_timeout", acc, 1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    do begin
      @(posedge clk);
      i++;
    end while (q.size() > 0 && i < 300);
    #1;
    chk("drain", q.size(), 0);
  endtask

  task automatic single(input int a, input int b, input int m,
                        input int es, input int ew, input int eo);
    in_a = a[5:0];
    in_b = b[5:0];
    in_mode = m[1:0];
    in_valid = 1'b1;
    @(negedge clk);
    chk("single_accept", rdy_s, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("single_lat1_idle", ov_s, 0);
    @(posedge clk);
    #1;
    chk("single_lat2_valid", ov_s, 1);
    chk("single_res_sat", res_s, es);
    chk("single_res_wrap", res_w, ew);
    chk("single_ovf_sat", of_s, eo);
    chk("single_ovf_wrap", of_w, eo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("reset_out_valid", ov_s, 0);
    chk("reset_in_ready", rdy_s, 1);
    chk("reset_ovf_count", cnt_s, 0);
    chk("reset_result", res_s, 0);

    // Pin the model with hand-computed values
    chk("model_m00", true_val(5, -3, 0), 18);
    chk("model_m01", true_val(3, -2, 1), -3);
    chk("model_m11", true_val(3, 1, 3), 5);
    chk("model_wrap_m00", wrap_of(true_val(15, 0, 0)), -4);
    chk("model_wrap_m10", wrap_of(true_val(0, -32, 2)), -32);
    chk("model_wrap_m11", wrap_of(true_val(-32, 31, 3)), 31);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beats and overflow cases
    single(5, -3, 0, 18, 18, 0);
    single(3, -2, 1, -3, -3, 0);
    single(3, 1, 3, 5, 5, 0);
    single(15, 0, 0, 31, -4, 1);
    single(10, 10, 1, 31, -24, 1);
    single(0, -32, 2, 31, -32, 1);
    single(-32, 31, 3, 31, 31, 1);

    // Backpressure: X, Y buffered, Z waits
    out_ready = 1'b0;
    fork
      begin
        send(3, -2, 1);
        send(5, -3, 0);
        send(3, 1, 3);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", rdy_s, 0);
        chk("bp_hold_x", res_s, -3);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_no_gap", ov_s, 1);
        end
      end
    join
    drain();

    // Random streaming with random backpressure
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 20; k++)
          send(s6($urandom_range(0, 63)), s6($urandom_range(0, 63)),
               $urandom_range(0, 3));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = $urandom_range(0, 1);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Counter: clear, three overflows
    ovf_clear = 1'b1;
    @(posedge clk);
    #1;
    ovf_clear = 1'b0;
    for (int k = 0; k < 3; k++) send(15, 0, 0);
    drain();
    chk("cnt_three", cnt_s, 3);

    // Clear wins over a simultaneous overflow transfer
    send(15, 0, 0);
    @(posedge clk);
    #1;
    ovf_clear = 1'b1;
    @(posedge clk);
    #1;
    ovf_clear = 1'b0;
    chk("cnt_clear_priority", cnt_s, 0);
    chk("cnt_clear_consumed", ov_s, 0);

    // Saturation of the counter
    for (int k = 0; k < 260; k++) send(10, 10, 1);
    drain();
    chk("cnt_saturated", cnt_s, 255);
    send(-32, 31, 3);
    drain();
    chk("cnt_stays_saturated", cnt_s, 255);

    // Reset with two beats buffered
    out_ready = 1'b0;
    send(10, 10, 1);
    send(5, -3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid_async", ov_s, 0);
    chk("rst_count_async", cnt_s, 0);
    chk("rst_in_ready", rdy_s, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("rst_release_in_ready", rdy_s, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_no_stale", ov_s, 0);
    end
    chk("final_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
